beta_pipe_ctrl: RTL

Pipeline Control Unit for the 5-stage core: sole driver of the `stall`/`flush` inputs of the PC register and the IF/DEC, DEC/EX, EX/MEM and MEM/WB pipeline registers. It resolves data-memory wait, exceptions, taken branches with multi-cycle fetch penalty, load-use hazards and instruction-fetch wait into one consistent set of stage controls every cycle. It also keeps a memory-wait watchdog and stall/flush performance counters.

---
 rtl/beta_pkg.sv | 33 +++
 rtl/beta_pctl_perfcnt.sv | 23 ++
 rtl/beta_pipe_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/beta_pkg.sv
// Shared types and constants for the beta core pipeline control unit.
package beta_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } pctl_state_t;

    typedef struct packed {
        logic pc_stall;
        logic ifdec_stall;
        logic ifdec_flush;
        logic decex_stall;
        logic decex_flush;
        logic exmem_stall;
        logic exmem_flush;
        logic memwb_flush;
    } pctl_ctrl_t;

    localparam logic [1:0] PCTL_NOP_PENALITY = 2'd0;

    // A flush on a pipe register always wins over a stall of the same register.
    function automatic pctl_ctrl_t pctl_resolve(input pctl_ctrl_t c);
        pctl_ctrl_t r;
        r = c;
        r.ifdec_stall = c.ifdec_stall & ~c.ifdec_flush;
        r.decex_stall = c.decex_stall & ~c.decex_flush;
        r.exmem_stall = c.exmem_stall & ~c.exmem_flush;
        return r;
    endfunction

endpackage

// File: rtl/beta_pctl_perfcnt.sv
// Wrapping event counter used for the pipeline-control performance statistics.
module beta_pctl_perfcnt #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_reg;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_reg <= '0;
        end else if (en_i) begin
            cnt_reg <= cnt_reg + Width'(1);
        end
    end

    assign cnt_o = cnt_reg;

endmodule

// File: rtl/beta_pipe_ctrl.sv
// Pipeline control unit: resolves memory wait, redirects and hazards into one
// consistent set of stall/flush controls, plus a memory watchdog and perf counters.
module beta_pipe_ctrl
    import beta_pkg::*;
#(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned MemTimeout = 255
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 ctl_imem_busy_i,
    input  logic                 ctl_load_use_i,
    input  logic                 ctl_branch_taken_i,
    input  logic                 ctl_except_i,
    input  logic [1:0]           ctl_penality_i,
    input  logic                 ctl_dmem_req_i,
    input  logic                 ctl_dmem_rvalid_i,
    output logic                 ctl_pc_stall_o,
    output logic                 ctl_ifdec_stall_o,
    output logic                 ctl_ifdec_flush_o,
    output logic                 ctl_decex_stall_o,
    output logic                 ctl_decex_flush_o,
    output logic                 ctl_exmem_stall_o,
    output logic                 ctl_exmem_flush_o,
    output logic                 ctl_memwb_flush_o,
    output logic                 ctl_mem_err_o,
    output logic [DataWidth-1:0] ctl_stall_cnt_o,
    output logic [DataWidth-1:0] ctl_flush_cnt_o
);

    localparam int unsigned WdWidth = (MemTimeout > 0) ? $clog2(MemTimeout + 1) : 1;
    localparam logic [WdWidth-1:0] WdLimit = WdWidth'(MemTimeout);

    pctl_state_t        state_reg, state_next;
    logic [1:0]         rcnt_reg, rcnt_next;
    logic [WdWidth-1:0] wd_reg, wd_next;

    pctl_ctrl_t ctrl_raw, ctrl;
    logic       mem_wait;
    logic       timeout;
    logic       err_now;
    logic       redirect;

    always_comb begin
        mem_wait   = ctl_dmem_req_i && !ctl_dmem_rvalid_i;
        timeout    = (MemTimeout != 0) && (state_reg == MEM_WAIT) && mem_wait
                     && (wd_reg == WdLimit);
        err_now    = (state_reg == ERR) || timeout;
        ctrl_raw   = '0;
        state_next = state_reg;
        rcnt_next  = rcnt_reg;
        wd_next    = wd_reg;
        redirect   = 1'b0;

        if (err_now) begin
            ctrl_raw.pc_stall    = 1'b1;
            ctrl_raw.ifdec_stall = 1'b1;
            ctrl_raw.decex_stall = 1'b1;
            ctrl_raw.exmem_stall = 1'b1;
            ctrl_raw.memwb_flush = 1'b1;
            state_next           = ERR;
        end else if (mem_wait) begin
            // Whole pipe freezes; redirect bubbles and lower hazards wait it out.
            ctrl_raw.pc_stall    = 1'b1;
            ctrl_raw.ifdec_stall = 1'b1;
            ctrl_raw.decex_stall = 1'b1;
            ctrl_raw.exmem_stall = 1'b1;
            ctrl_raw.memwb_flush = 1'b1;
            state_next           = MEM_WAIT;
            wd_next              = (state_reg == RUN) ? WdWidth'(1) : wd_reg + WdWidth'(1);
        end else begin
            state_next = RUN;
            if (ctl_except_i) begin
                ctrl_raw.ifdec_flush = 1'b1;
                ctrl_raw.decex_flush = 1'b1;
                ctrl_raw.exmem_flush = 1'b1;
                rcnt_next            = ctl_penality_i;
                redirect             = 1'b1;
            end else if (ctl_branch_taken_i) begin
                ctrl_raw.ifdec_flush = 1'b1;
                ctrl_raw.decex_flush = 1'b1;
                rcnt_next            = ctl_penality_i;
                redirect             = 1'b1;
            end else if (rcnt_reg != PCTL_NOP_PENALITY) begin
                ctrl_raw.ifdec_flush = 1'b1;
                rcnt_next            = rcnt_reg - 2'd1;
            end else if (ctl_load_use_i) begin
                ctrl_raw.pc_stall    = 1'b1;
                ctrl_raw.ifdec_stall = 1'b1;
                ctrl_raw.decex_flush = 1'b1;
            end else if (ctl_imem_busy_i) begin
                ctrl_raw.pc_stall    = 1'b1;
                ctrl_raw.ifdec_flush = 1'b1;
            end
        end

        ctrl = pctl_resolve(ctrl_raw);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= RUN;
            rcnt_reg  <= PCTL_NOP_PENALITY;
            wd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            rcnt_reg  <= rcnt_next;
            wd_reg    <= wd_next;
        end
    end

    // Controls act in the same cycle; held at zero while reset is asserted.
    assign ctl_pc_stall_o    = rstn_i & ctrl.pc_stall;
    assign ctl_ifdec_stall_o = rstn_i & ctrl.ifdec_stall;
    assign ctl_ifdec_flush_o = rstn_i & ctrl.ifdec_flush;
    assign ctl_decex_stall_o = rstn_i & ctrl.decex_stall;
    assign ctl_decex_flush_o = rstn_i & ctrl.decex_flush;
    assign ctl_exmem_stall_o = rstn_i & ctrl.exmem_stall;
    assign ctl_exmem_flush_o = rstn_i & ctrl.exmem_flush;
    assign ctl_memwb_flush_o = rstn_i & ctrl.memwb_flush;
    assign ctl_mem_err_o     = rstn_i & err_now;

    logic [1:0]           cnt_en;
    logic [DataWidth-1:0] cnt_val [2];

    assign cnt_en = {redirect, ctrl.pc_stall};

    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        beta_pctl_perfcnt #(
            .Width (DataWidth)
        ) u_cnt (
            .clk_i  (clk_i),
            .rstn_i (rstn_i),
            .en_i   (cnt_en[gi]),
            .cnt_o  (cnt_val[gi])
        );
    end

    assign ctl_stall_cnt_o = cnt_val[0];
    assign ctl_flush_cnt_o = cnt_val[1];

endmodule
